// File: rtl/riscv_pkg.sv
// Shared core constants and the sequential-PC helper used by the fetch path.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_INIT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam int CNT_W = 3;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of {pc, instr} entries; the head is shown combinationally from the registered storage.
// Push and pop may coincide at any occupancy, including full. Flush wins over both.
module fetch_fifo import riscv_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset: validity is tracked entirely by cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-order responses buffered one cycle before decode.
// Decode stalls via inst_ready; memory stalls via imem_req_ready; redirect flushes and drops in-flight responses.
module fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_INIT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);
  localparam int SW = CNT_W + 1;

  logic [XLEN-1:0]   pc_q, pc_d, rpc_q, rpc_d;
  logic [CNT_W-1:0]  out_q, out_d, drop_q, drop_d, buf_count, in_flight;
  logic              fault_q, fault_d;
  logic              buf_full, buf_empty, hs, resp_live, pop, credit_ok;
  logic [2*XLEN-1:0] buf_head;

  // Every request holds a buffer slot until decode drains it, so the buffer cannot overflow.
  assign credit_ok      = (SW'(out_q) + SW'(buf_count)) < SW'(DEPTH);
  assign imem_req_valid = rst_n && credit_ok && !buf_full && !fault_q && !redirect;
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (drop_q == '0) && !redirect;
  assign inst_valid     = !buf_empty;
  assign pop            = inst_valid && inst_ready;
  assign {inst_pc, instruction} = buf_head;
  assign fetch_fault    = fault_q;
  assign in_flight      = out_q + CNT_W'(hs) - CNT_W'(imem_resp_valid);

  // rpc_q is the PC of the next live response; stale ones never advance it.
  always_comb begin
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    out_d   = in_flight;
    drop_d  = drop_q;
    fault_d = fault_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      rpc_d   = redirect_pc;
      drop_d  = in_flight;
      fault_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (hs) pc_d = next_pc(pc_q);
      if (resp_live) rpc_d = next_pc(rpc_q);
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (resp_live),
    .push_dat ({rpc_q, imem_resp_data}),
    .pop      (pop),
    .flush    (redirect),
    .head     (buf_head),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction-buffer entries and also the maximum number of outstanding memory requests; legal values are 2 or 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 The block SHALL have port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-008 The block SHALL have port imem_resp_valid, input, 1 bit: response data valid; responses return in request order, no backpressure.
REQ-009 The block SHALL have port imem_resp_data, input, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port redirect, input, 1 bit: a taken branch or jump; flush the buffer and restart fetching.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: the new fetch address.
REQ-012 The block SHALL have port inst_valid, output, 1 bit: instruction/inst_pc valid toward the decode stage.
REQ-013 The block SHALL have port inst_ready, input, 1 bit: decode consumes the instruction.
REQ-014 The block SHALL have port instruction, output, 32 bits: the instruction word delivered to decode.
REQ-015 The block SHALL have port inst_pc, output, 32 bits: the address of the delivered instruction.
REQ-016 The block SHALL have port fetch_fault, output, 1 bit: sticky flag set when a redirect target is misaligned.

Function
REQ-017 The block SHALL complete a request handshake when imem_req_valid && imem_req_ready; on handshake, pc <= pc + 4, with 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
REQ-018 The block SHALL assert imem_req_valid only when (outstanding + buffered) < DEPTH, no fault is pending and redirect is 0; imem_req_addr SHALL equal pc.
REQ-019 The block SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 The block SHALL maintain an outstanding counter: +1 on handshake, -1 on response, unchanged when both occur in the same cycle; it SHALL never exceed DEPTH.
REQ-021 The block SHALL push a response into the buffer as {pc_of_request, imem_resp_data} unless it is being dropped; the buffer has a FIFO of request PCs in parallel.
REQ-022 The block SHALL drive inst_valid from the buffer's not-empty state; instruction and inst_pc SHALL be the buffer head; pop occurs on inst_valid && inst_ready.
REQ-023 The minimum latency from response to inst_valid SHALL be 1 cycle (registered; no bypass).
REQ-024 The block SHALL allow a push and a pop in the same cycle at any occupancy, including full, where the count is unchanged; the credit rule in REQ-018 guarantees no overflow.
REQ-025 On redirect, the block SHALL in that cycle: clear the buffer, set pc <= redirect_pc, set drop_count <= outstanding including any handshake completing this cycle, minus any response arriving this cycle, and force inst_valid=0 from the next cycle.
REQ-026 While drop_count > 0, each response SHALL be discarded and decrement drop_count, and SHALL NOT be pushed.
REQ-027 A redirect SHALL override a simultaneous pop; a popped instruction in a redirect cycle counts as consumed by decode.
REQ-028 If redirect_pc[1:0] != 0, the block SHALL set fetch_fault=1, stop issuing requests, and still flush and drop; a later redirect with an aligned target SHALL clear fetch_fault and resume.

Reset
REQ-029 While rst_n=0, the block SHALL set pc=RESET_PC, outstanding=0, drop_count=0, the buffer empty, fetch_fault=0, imem_req_valid=0 and inst_valid=0, asynchronously.
REQ-030 On reset, the block SHALL discard responses to requests issued before reset; memory is reset together with this block.
REQ-031 The first request SHALL be presented in the first cycle after rst_n deasserts.

Structure
REQ-032 The shared package riscv_pkg SHALL hold XLEN=32, the reset PC constant and the NOP encoding 32'h0000_0013.
REQ-033 The buffer SHALL be one sub-module, fetch_fifo, parameterised by DEPTH and a width of 64 bits ({pc, instr}), with push, pop, flush, full, empty and count outputs.

Verification
REQ-034 The bench SHALL release reset with memory at 1-cycle latency and inst_ready=1, and check that the addresses are 0, 4, 8, 12 and that each instruction appears 1 cycle after its response, in order.
REQ-035 The bench SHALL hold inst_ready=0 for 10 cycles, and check that at most DEPTH requests are issued, that inst_valid stays held with the same head, and that no instruction is lost on release.
REQ-036 The bench SHALL redirect to 32'h0000_0100 with 2 requests outstanding, and check that both stale responses are dropped and that the next inst_pc is 32'h100 with the correct data.
REQ-037 The bench SHALL hold imem_req_ready=0 for 5 cycles, and check that imem_req_addr stays constant and outstanding stays constant.
REQ-038 The bench SHALL redirect to 32'h0000_0102, and check that fetch_fault=1 and no requests follow; it SHALL then redirect to 32'h0000_0200 and check that fault clears and fetching starts at 32'h200.
REQ-039 The bench SHALL start with pc=32'hFFFF_FFF8 via redirect, and check the addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
